// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame geometry, command encoding and controller states.
// Reused by the SPI slave and the RAM controller so both agree on the frame layout.
package spi_pkg;

  localparam int FRAME_WIDTH = 8;
  localparam int CTRL_WIDTH  = 2;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    TX,
    WAIT_REL
  } state_t;

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port RAM with synchronous write and registered read.
// The read register resets to zero and serves as the controller's dout register.
module spi_ram_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q, rdata_d;

  // NOTE: the array has no reset branch; resetting it would turn the RAM into flops.
  always_ff @(posedge clk) begin
    if (rst_n && we) begin
      mem_q[addr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder between an SPI slave and a small RAM: one command per rx_valid pulse,
// address registers with wrap-around auto-increment, and the tx handshake back to the slave.
module spi_ram_ctrl #(
  parameter int FRAME_WIDTH = spi_pkg::FRAME_WIDTH,
  parameter int CTRL_WIDTH  = spi_pkg::CTRL_WIDTH,
  parameter int MEM_DEPTH   = 256
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [FRAME_WIDTH+CTRL_WIDTH-1:0] din,
  input  logic                        rx_valid,
  output logic [FRAME_WIDTH-1:0]      dout,
  output logic                        tx_valid
);

  import spi_pkg::*;

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int FW = FRAME_WIDTH + CTRL_WIDTH;

  state_t          state_q, state_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic            tx_valid_q, tx_valid_d;

  logic            mem_we, mem_re;
  logic [AW-1:0]   mem_addr;
  cmd_t            cmd;
  logic [AW-1:0]   payload_addr;

  assign cmd          = cmd_t'(frame_q[FW-1 -: 2]);
  assign payload_addr = frame_q[AW-1:0];

  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    return (a == AW'(MEM_DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    tx_valid_d = tx_valid_q;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_addr   = wr_addr_q;

    unique case (state_q)
      IDLE: begin
        if (rx_valid) begin
          frame_d = din;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = WAIT_REL;
        unique case (cmd)
          WR_ADDR: wr_addr_d = payload_addr;
          WR_DATA: begin
            mem_we    = 1'b1;
            wr_addr_d = addr_inc(wr_addr_q);
          end
          RD_ADDR: rd_addr_d = payload_addr;
          RD_DATA: begin
            mem_re     = 1'b1;
            mem_addr   = rd_addr_q;
            rd_addr_d  = addr_inc(rd_addr_q);
            tx_valid_d = 1'b1;
            state_d    = TX;
          end
        endcase
      end
      TX: begin
        if (!rx_valid) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      WAIT_REL: begin
        if (!rx_valid) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      frame_q    <= '0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  spi_ram_mem #(
    .WIDTH (FRAME_WIDTH),
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (frame_q[FRAME_WIDTH-1:0]),
    .rdata (dout)
  );

  assign tx_valid = tx_valid_q;

endmodule

// File: doc/spi_ram_ctrl.md
SPI_RAM_CTRL -- requirements
Module: spi_ram_ctrl

Interface
REQ-001 SHALL have parameter FRAME_WIDTH, default 8, data/address bits per frame.
REQ-002 SHALL have parameter CTRL_WIDTH, default 2, command bits per frame.
REQ-003 SHALL have parameter MEM_DEPTH, default 256, words of FRAME_WIDTH bits; address width = $clog2(MEM_DEPTH) <= FRAME_WIDTH.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port din  input  FRAME_WIDTH+CTRL_WIDTH  frame from SPI slave: [MSB-:CTRL_WIDTH] command, [FRAME_WIDTH-1:0] payload.
REQ-007 SHALL have port rx_valid  input  1  frame valid; level, held high by the slave until its chip-select releases.
REQ-008 SHALL have port dout  output  FRAME_WIDTH  read data to SPI slave.
REQ-009 SHALL have port tx_valid  output  1  dout valid; the slave shifts dout out while high.

Function
REQ-010 SHALL decode commands: 00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA.
REQ-011 SHALL implement FSM states IDLE, EXEC, TX, WAIT_REL.
REQ-012 IDLE: when rx_valid=1, SHALL capture din into an internal frame register and go to EXEC; otherwise stay.
REQ-013 EXEC (exactly one cycle): WR_ADDR SHALL load wr_addr <= payload; RD_ADDR SHALL load rd_addr <= payload.
REQ-014 EXEC, WR_DATA: SHALL write mem[wr_addr] <= payload, then wr_addr <= wr_addr+1.
REQ-015 EXEC, RD_DATA: SHALL load dout <= mem[rd_addr], set tx_valid <= 1, then rd_addr <= rd_addr+1.
REQ-016 Address increments SHALL wrap from MEM_DEPTH-1 to 0; payload bits above the address width SHALL be ignored.
REQ-017 EXEC SHALL go to TX after RD_DATA and to WAIT_REL after any other command.
REQ-018 TX: SHALL hold tx_valid=1 and dout stable while rx_valid=1; on rx_valid=0 SHALL clear tx_valid and go to IDLE.
REQ-019 WAIT_REL: SHALL stay while rx_valid=1; on rx_valid=0 SHALL go to IDLE.
REQ-020 Each rx_valid high period SHALL execute exactly one command, regardless of its length.
REQ-021 Latency: rx_valid first sampled high at edge E0, command executed at edge E1; for RD_DATA, tx_valid and dout are visible after E1.
REQ-022 din SHALL be sampled only in IDLE; changes on din in other states SHALL have no effect.
REQ-023 The first rx_valid after reset SHALL be accepted even if rx_valid was already high when reset released.
REQ-024 tx_valid SHALL be 1 only in TX; dout SHALL change only in EXEC for RD_DATA, or on reset.

Reset
REQ-025 When rst_n=0 at a clock edge: state <= IDLE; tx_valid, dout, wr_addr, rd_addr, and the frame register <= 0.
REQ-026 Memory contents SHALL NOT be reset.
REQ-027 Reset in EXEC SHALL suppress that cycle's memory write and address updates.
REQ-028 Reset in TX SHALL drop tx_valid at that edge.

Structure
REQ-029 Shared package spi_pkg SHALL hold FRAME_WIDTH, CTRL_WIDTH, the command enum (cmd_t), and the controller state enum, for reuse with the SPI slave.
REQ-030 Memory SHALL be a sub-module spi_ram_mem: single-port, synchronous write, registered read, one access per cycle (EXEC only).
REQ-031 spi_ram_ctrl SHALL contain the FSM, address registers, and output registers only.

Verification
REQ-032 Sequence: WR_ADDR 0x10, WR_DATA 0xA5, RD_ADDR 0x10, RD_DATA; each rx_valid held 5 cycles -> tx_valid rises 2 edges after RD_DATA rx_valid, dout=0xA5 held until rx_valid falls.
REQ-033 WR_ADDR 0xFF, WR_DATA 0x11, WR_DATA 0x22; read back from 0xFF -> 0x11 at 0xFF, 0x22 at 0x00 (wrap); second RD_DATA without RD_ADDR returns mem[0x00].
REQ-034 WR_DATA with rx_valid held 20 cycles and din changed mid-pulse -> exactly one write of the first payload; wr_addr advances by 1.
REQ-035 Assert rst_n=0 during TX after a RD_DATA -> tx_valid=0 and dout=0 at that edge; state IDLE; memory contents unchanged.
REQ-036 Back-to-back frames with rx_valid low for 1 cycle between them -> both commands executed, in order.
